hazard_scoreboard: RTL and testbench

//  Parametrised Tuse/Tnew hazard unit for the multi-stage MIPS pipeline. Tracks in-flight register writers in a
//  per-stage slot pipeline and stalls ID when a source is not ready in time. Reports the ID-stage forwarding source
//  and runs an internal mult/div busy countdown, so HI/LO instructions stall without an external busy signal.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/md_countdown.sv | 37 +++
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the Tuse/Tnew hazard scoreboard.
// Slot layout, tnew ageing and forward-select encodings.
package hazard_pkg;

    localparam int SLOT_RA_W = 5;
    localparam int SLOT_TW   = 2;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RA_W-1:0] dst;
        logic [SLOT_TW-1:0]   tnew;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // fwd select 0 means "read the register file"; k>0 means slot k-1
    localparam int FWD_REGFILE = 0;

    function automatic logic [SLOT_TW-1:0] tnew_sat_dec(
        input logic [SLOT_TW-1:0] t
    );
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/md_countdown.sv
// Mult/div busy countdown: load on start, decrement to zero, hold.
// A load while already busy restarts the full latency.
module md_countdown #(
    parameter int LAT = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic busy
);

    localparam int W = $clog2(LAT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: reload, otherwise count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: per-stage writer slots, ID stall and forwarding,
// internal mult/div busy tracking and a stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RA_W   = SLOT_RA_W,
    parameter int TW     = SLOT_TW,
    parameter int MD_LAT = 5,
    parameter int CNT_W  = 32,
    localparam int SELW  = $clog2(NSTAGE + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [TW-1:0]    id_tuse_rs,
    input  logic [TW-1:0]    id_tuse_rt,
    input  logic             id_wr,
    input  logic [RA_W-1:0]  id_dst,
    input  logic [TW-1:0]    id_tnew,
    input  logic             id_hilo,
    input  logic             md_start,
    input  logic             flush,
    output logic             stall,
    output logic [SELW-1:0]  fwd_rs_sel,
    output logic [SELW-1:0]  fwd_rt_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    slot_t slot_q [NSTAGE];
    slot_t slot_d [NSTAGE];

    logic [NSTAGE-1:0] hit_rs, hit_rt;
    logic              rs_match, rt_match;
    logic [TW-1:0]     rs_tnew, rt_tnew;
    logic [SELW-1:0]   rs_sel, rt_sel;
    logic              stall_rs, stall_rt, stall_hilo;
    logic              load_slot0;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_match
        assign hit_rs[g] = slot_q[g].valid && (slot_q[g].dst == id_rs)
                           && (id_rs != '0) && id_use_rs;
        assign hit_rt[g] = slot_q[g].valid && (slot_q[g].dst == id_rt)
                           && (id_rt != '0) && id_use_rt;
    end

    // priority pick: scan oldest to youngest so the youngest hit wins
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        rs_tnew  = '0;
        rt_tnew  = '0;
        rs_sel   = SELW'(FWD_REGFILE);
        rt_sel   = SELW'(FWD_REGFILE);
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (hit_rs[i]) begin
                rs_match = 1'b1;
                rs_tnew  = slot_q[i].tnew;
                rs_sel   = SELW'(i + 1);
            end
            if (hit_rt[i]) begin
                rt_match = 1'b1;
                rt_tnew  = slot_q[i].tnew;
                rt_sel   = SELW'(i + 1);
            end
        end
    end

    // stall and forward decisions; flush deliberately plays no part here
    always_comb begin
        stall_rs   = rs_match && (rs_tnew > id_tuse_rs);
        stall_rt   = rt_match && (rt_tnew > id_tuse_rt);
        stall_hilo = id_hilo && (md_busy || md_start);
        stall      = id_valid && (stall_rs || stall_rt || stall_hilo);
        fwd_rs_sel = (rs_match && rs_tnew == '0) ? rs_sel : SELW'(FWD_REGFILE);
        fwd_rt_sel = (rt_match && rt_tnew == '0) ? rt_sel : SELW'(FWD_REGFILE);
    end

    // slot shift: new writer or bubble into EX, age the rest, flush kills young
    always_comb begin
        load_slot0 = id_valid && id_wr && (id_dst != '0) && !stall && !flush;
        slot_d[0]  = SLOT_EMPTY;
        if (load_slot0) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].dst   = id_dst;
            slot_d[0].tnew  = id_tnew;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            slot_d[i]      = slot_q[i-1];
            slot_d[i].tnew = tnew_sat_dec(slot_q[i-1].tnew);
            if (flush && i <= NSTAGE - 2) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end
        stall_cycles_d = stall_cycles_q + CNT_W'(stall);
    end

    // slot and statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTAGE; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                slot_q[i] <= slot_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

    md_countdown #(
        .LAT (MD_LAT)
    ) u_md (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (md_start && !flush),
        .busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios
// plus randomized traffic against an age-based in-flight model.
module tb_hazard_scoreboard;

    localparam int NS  = 3;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic [1:0]  id_tuse_rs, id_tuse_rt;
    logic        id_wr;
    logic [4:0]  id_dst;
    logic [1:0]  id_tnew;
    logic        id_hilo, md_start, flush;
    logic        stall;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic        md_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int fails  = 0;

    // model state: in-flight writers, youngest first
    int q_dst[$];
    int q_tn[$];
    int q_age[$];
    int m_md;
    int unsigned m_cnt;

    hazard_scoreboard #(
        .NSTAGE (NS),
        .MD_LAT (LAT),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_tuse_rs   (id_tuse_rs),
        .id_tuse_rt   (id_tuse_rt),
        .id_wr        (id_wr),
        .id_dst       (id_dst),
        .id_tnew      (id_tnew),
        .id_hilo      (id_hilo),
        .md_start     (md_start),
        .flush        (flush),
        .stall        (stall),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void m_find(input int s, input bit u,
                                   output int sel, output int rem);
        sel = 0;
        rem = 0;
        if (u && s != 0) begin
            for (int k = 0; k < q_dst.size(); k++) begin
                if (q_dst[k] == s) begin
                    sel = q_age[k] + 1;
                    rem = (q_tn[k] > q_age[k]) ? q_tn[k] - q_age[k] : 0;
                    break;
                end
            end
        end
    endfunction

    function automatic void m_out(output bit st, output int rsel,
                                  output int tsel, output bit busy);
        int a, ra, b, rb;
        m_find(int'(id_rs), id_use_rs, a, ra);
        m_find(int'(id_rt), id_use_rt, b, rb);
        busy = (m_md > 0);
        st = id_valid && ((a != 0 && ra > int'(id_tuse_rs))
                       || (b != 0 && rb > int'(id_tuse_rt))
                       || (id_hilo && (busy || md_start)));
        rsel = (a != 0 && ra == 0) ? a : 0;
        tsel = (b != 0 && rb == 0) ? b : 0;
    endfunction

    task automatic m_reset();
        q_dst.delete();
        q_tn.delete();
        q_age.delete();
        m_md  = 0;
        m_cnt = 0;
    endtask

    // one clock edge, advancing the model alongside the DUT
    task automatic cyc();
        bit st, bz;
        int a, b;
        int nd[$], nt[$], na[$];
        m_out(st, a, b, bz);
        @(posedge clk);
        if (st) m_cnt++;
        if (md_start && !flush) m_md = LAT;
        else if (m_md > 0) m_md--;
        for (int k = 0; k < q_dst.size(); k++) begin
            int age = q_age[k] + 1;
            if (age < NS && !(flush && age <= NS - 2)) begin
                nd.push_back(q_dst[k]);
                nt.push_back(q_tn[k]);
                na.push_back(age);
            end
        end
        if (id_valid && id_wr && id_dst != 0 && !st && !flush) begin
            nd.push_front(int'(id_dst));
            nt.push_front(int'(id_tnew));
            na.push_front(0);
        end
        q_dst = nd;
        q_tn  = nt;
        q_age = na;
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_tuse_rs = 0; id_tuse_rt = 0; id_wr = 0; id_dst = 0; id_tnew = 0;
        id_hilo = 0; md_start = 0; flush = 0;
    endtask

    task automatic writer(input int d, input int t);
        idle();
        id_valid = 1; id_wr = 1; id_dst = 5'(d); id_tnew = 2'(t);
    endtask

    task automatic reader(input int r, input int tu);
        idle();
        id_valid = 1; id_rs = 5'(r); id_rt = 5'(r);
        id_use_rs = 1; id_use_rt = 1;
        id_tuse_rs = 2'(tu); id_tuse_rt = 2'(tu);
    endtask

    task automatic drain();
        idle();
        repeat (NS + 1) cyc();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        m_reset();
        #7;
        reader(7, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || md_busy !== 1'b0
            || stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_state got stall=%0b sel=%0d busy=%0b cnt=%0d want 0/0/0/0",
                     stall, fwd_rs_sel, md_busy, stall_cycles);
        end
        idle();
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        bit st, bz;
        int a, b;
        writer(2, 2);
        cyc();
        reader(2, 1);
        id_wr = 1; id_dst = 3; id_tnew = 1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL load_use_stall got %0b want 1", stall);
        end
        cyc();
        @(negedge clk);
        m_out(st, a, b, bz);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'(a) || fwd_rt_sel !== 2'(b)) begin
            fails++;
            $display("FAIL load_use_release got stall=%0b rs=%0d rt=%0d want 0 %0d %0d",
                     stall, fwd_rs_sel, fwd_rt_sel, a, b);
        end
        cyc();
        drain();
    endtask

    task automatic test_branch();
        writer(4, 1);
        cyc();
        reader(4, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL branch_stall got %0b want 1", stall);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd2) begin
            fails++;
            $display("FAIL branch_fwd_mem got stall=%0b rs=%0d rt=%0d want 0 2 2",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        drain();
        writer(4, 1);
        cyc();
        reader(4, 1);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
            fails++;
            $display("FAIL branch_tuse1 got stall=%0b rs=%0d want 0 0",
                     stall, fwd_rs_sel);
        end
        drain();
    endtask

    task automatic test_youngest();
        writer(5, 1);
        cyc();
        writer(5, 1);
        cyc();
        reader(5, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || fwd_rs_sel !== 2'd0) begin
            fails++;
            $display("FAIL youngest_wins got stall=%0b rs=%0d want 1 0",
                     stall, fwd_rs_sel);
        end
        drain();
    endtask

    task automatic test_zero_reg();
        for (int k = 0; k < NS; k++) begin
            writer(0, 3);
            cyc();
        end
        reader(0, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            fails++;
            $display("FAIL zero_reg got stall=%0b rs=%0d rt=%0d want 0 0 0",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        drain();
    endtask

    task automatic test_md_busy();
        int seen = 0;
        idle();
        id_valid = 1; id_hilo = 1; md_start = 1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || md_busy !== 1'b0) begin
            fails++;
            $display("FAIL md_start_cycle got stall=%0b busy=%0b want 1 0",
                     stall, md_busy);
        end
        if (stall === 1'b1) seen++;
        cyc();
        md_start = 0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b1 || md_busy !== 1'b1) begin
                fails++;
                $display("FAIL md_busy_cycle%0d got stall=%0b busy=%0b want 1 1",
                         k, stall, md_busy);
            end
            if (stall === 1'b1) seen++;
            cyc();
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0 || seen != LAT + 1) begin
            fails++;
            $display("FAIL md_done got stall=%0b busy=%0b stalls=%0d want 0 0 %0d",
                     stall, md_busy, seen, LAT + 1);
        end
        checks++;
        if (stall_cycles !== m_cnt) begin
            fails++;
            $display("FAIL md_stall_count got %0d want %0d", stall_cycles, m_cnt);
        end
        drain();
    endtask

    task automatic test_flush();
        idle();
        md_start = 1;
        cyc();
        writer(6, 2);
        cyc();
        reader(6, 0);
        flush = 1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL flush_stall_indep got %0b want 1", stall);
        end
        cyc();
        flush = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || md_busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_after got stall=%0b rs=%0d busy=%0b want 0 0 1",
                     stall, fwd_rs_sel, md_busy);
        end
        drain();
        repeat (LAT) cyc();
    endtask

    task automatic test_random();
        bit st, bz;
        int a, b;
        for (int n = 0; n < 600; n++) begin
            id_valid   = ($urandom_range(0, 7) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom);
            id_use_rt  = 1'($urandom);
            id_tuse_rs = 2'($urandom);
            id_tuse_rt = 2'($urandom);
            id_wr      = 1'($urandom);
            id_dst     = 5'($urandom_range(0, 3));
            id_tnew    = 2'($urandom);
            id_hilo    = ($urandom_range(0, 3) == 0);
            md_start   = ($urandom_range(0, 11) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            m_out(st, a, b, bz);
            checks++;
            if (stall !== st || fwd_rs_sel !== 2'(a) || fwd_rt_sel !== 2'(b)
                || md_busy !== bz) begin
                fails++;
                $display("FAIL rand_cycle%0d got %0b/%0d/%0d/%0b want %0b/%0d/%0d/%0b",
                         n, stall, fwd_rs_sel, fwd_rt_sel, md_busy, st, a, b, bz);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cycles !== m_cnt) begin
            fails++;
            $display("FAIL rand_stall_count got %0d want %0d", stall_cycles, m_cnt);
        end
    endtask

    task automatic test_reset_mid();
        writer(9, 3);
        md_start = 1;
        cyc();
        reader(9, 0);
        #2;
        reset_n = 0;
        m_reset();
        #1;
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0 || fwd_rs_sel !== 2'd0
            || stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid got stall=%0b busy=%0b rs=%0d cnt=%0d want 0/0/0/0",
                     stall, md_busy, fwd_rs_sel, stall_cycles);
        end
        @(negedge clk);
        reset_n = 1;
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_release got stall=%0b cnt=%0d want 0 0",
                     stall, stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_zero_reg();
        test_md_busy();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
